// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush controller: per-stage stall vector, exception/ERET redirect, MEM watchdog.
// Latency: stall/flush/new_pc/timeout_o are combinational from the requests; FLUSH lasts one cycle.
// Backpressure: the deepest stalling stage holds itself and every earlier stage; a flush overrides all stalls.
//
// Ports:
//   clk, rst                      - clock; asynchronous active-high reset
//   stallreq_from_{if,id,ex,mem}  - per-stage stall requests
//   excp_req_i, excp_type_i, epc_i - exception committed in MEM, its code, ERET return address
//   perf_clr_i                    - synchronous clear of the performance counters
//   stall[5:0]                    - hold vector {WB,MEM,EX,ID,IF,PC}
//   flush, new_pc                 - pipeline flush and redirect target (new_pc is 0 when not flushing)
//   timeout_o                     - MEM watchdog fired this cycle
//   stall_cycles_o, flush_count_o - performance counters
// Optional feature: define STALL_PERF_CNT_EN to build the performance counters; otherwise they read 0.

module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic        excp_req_i,
    input  logic [31:0] excp_type_i,
    input  logic [31:0] epc_i,
    input  logic        perf_clr_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        timeout_o,
    output logic [31:0] stall_cycles_o,
    output logic [15:0] flush_count_o
);

    localparam logic [31:0] EXCP_ERET = 32'h0000000e;
    localparam logic [31:0] EXCP_VEC  = 32'h00000020;
    localparam logic [31:0] TMO_VEC   = 32'h00000040;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [7:0]  wd_q, wd_d;
    logic [5:0]  stall_c;
    logic        flush_c;
    logic        timeout_c;
    logic [31:0] new_pc_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wd_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wd_d      = 8'd0;      // any cycle not extending a MEM stall clears the watchdog
        stall_c   = 6'b000000;
        flush_c   = 1'b0;
        timeout_c = 1'b0;
        new_pc_c  = 32'h0;
        case (state_q)
            RUN: begin
                if (excp_req_i) begin
                    // exception wins over a simultaneous watchdog fire
                    flush_c  = 1'b1;
                    new_pc_c = (excp_type_i == EXCP_ERET) ? epc_i : EXCP_VEC;
                    state_d  = FLUSH;
                end else if (stallreq_from_mem && (wd_q == 8'hFF)) begin
                    flush_c   = 1'b1;
                    timeout_c = 1'b1;
                    new_pc_c  = TMO_VEC;
                    state_d   = FLUSH;
                end else begin
                    if (stallreq_from_mem)     stall_c = 6'b011111;
                    else if (stallreq_from_ex) stall_c = 6'b001111;
                    else if (stallreq_from_id) stall_c = 6'b000111;
                    else if (stallreq_from_if) stall_c = 6'b000011;
                    if (stallreq_from_mem) wd_d = wd_q + 8'd1;
                end
            end
            FLUSH: begin
                // flush already issued last cycle; requests are ignored here
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs are forced low while reset is held, without waiting for a clock edge.
    assign stall     = rst ? 6'b000000 : stall_c;
    assign flush     = rst ? 1'b0      : flush_c;
    assign timeout_o = rst ? 1'b0      : timeout_c;
    assign new_pc    = rst ? 32'h0     : new_pc_c;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] flush_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 16'd0;
        end else if (perf_clr_i) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 16'd0;
        end else begin
            if (stall[0] && (stall_cycles_q != 32'hFFFFFFFF)) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (flush && (flush_count_q != 16'hFFFF))         flush_count_q  <= flush_count_q + 16'd1;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr_i;
    assign stall_cycles_o  = 32'd0;
    assign flush_count_o   = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_if, s_id, s_ex, s_mem;
    logic        excp_req;
    logic [31:0] excp_type, epc;
    logic        perf_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        timeout;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    int checks = 0;
    int errors = 0;

    // reference model state: cycles since the MEM request started, and whether last cycle flushed
    int     m_streak;
    bit     m_after_flush;
    longint m_stall_cnt, m_flush_cnt;

    // what the DUT showed in the most recent step
    logic [5:0]  o_stall;
    logic        o_flush, o_timeout;
    logic [31:0] o_new_pc;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .stallreq_from_if(s_if), .stallreq_from_id(s_id),
        .stallreq_from_ex(s_ex), .stallreq_from_mem(s_mem),
        .excp_req_i(excp_req), .excp_type_i(excp_type), .epc_i(epc),
        .perf_clr_i(perf_clr),
        .stall(stall), .flush(flush), .new_pc(new_pc), .timeout_o(timeout),
        .stall_cycles_o(stall_cycles), .flush_count_o(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_streak = 0; m_after_flush = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    // One clock cycle: inputs already set just after the previous edge.
    task automatic step();
        logic [5:0]  e_stall;
        logic        e_flush, e_tmo;
        logic [31:0] e_pc;
        int depth;
        #4;
        e_stall = 0; e_flush = 0; e_tmo = 0; e_pc = 0;
        if (!rst && !m_after_flush) begin
            if (excp_req) begin
                e_flush = 1;
                e_pc = (excp_type == 32'he) ? epc : 32'h20;
            end else if (s_mem && m_streak == 255) begin
                e_flush = 1; e_tmo = 1; e_pc = 32'h40;
            end else begin
                depth = s_mem ? 5 : s_ex ? 4 : s_id ? 3 : s_if ? 2 : 0;
                e_stall = 6'((1 << depth) - 1);
            end
        end
        o_stall = stall; o_flush = flush; o_timeout = timeout; o_new_pc = new_pc;
        chk("stall", {26'd0, stall}, {26'd0, e_stall});
        chk("flush", {31'd0, flush}, {31'd0, e_flush});
        chk("timeout", {31'd0, timeout}, {31'd0, e_tmo});
        chk("new_pc", new_pc, e_pc);
`ifdef STALL_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, 32'(m_stall_cnt));
        chk("flush_count", {16'd0, flush_count}, 32'(m_flush_cnt));
`else
        chk("stall_cycles", stall_cycles, 32'd0);
        chk("flush_count", {16'd0, flush_count}, 32'd0);
`endif
        @(posedge clk);
        if (rst) model_reset();
        else begin
            m_streak = (!m_after_flush && !e_flush && s_mem) ? m_streak + 1 : 0;
            if (perf_clr) begin
                m_stall_cnt = 0; m_flush_cnt = 0;
            end else begin
                if (e_stall[0] && m_stall_cnt < 64'hFFFFFFFF) m_stall_cnt++;
                if (e_flush && m_flush_cnt < 64'hFFFF) m_flush_cnt++;
            end
            m_after_flush = e_flush;
        end
        #1;
    endtask

    task automatic idle();
        s_if = 0; s_id = 0; s_ex = 0; s_mem = 0;
        excp_req = 0; excp_type = 0; epc = 0; perf_clr = 0;
    endtask

    initial begin
        int fire_idx, stall_run;
        idle();
        rst = 1;
        model_reset();
        #1;
        chk("reset_stall", {26'd0, stall}, 32'd0);
        chk("reset_new_pc", new_pc, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        step();

        // ID + MEM together, then MEM drops
        s_id = 1; s_mem = 1; step();
        chk("id_mem_stall", {26'd0, o_stall}, 32'h1f);
        s_mem = 0; step();
        chk("id_only_stall", {26'd0, o_stall}, 32'h07);
        idle(); step();

        // ERET with a held EX request
        s_ex = 1; excp_req = 1; excp_type = 32'he; epc = 32'h80001234; step();
        chk("eret_flush", {31'd0, o_flush}, 32'd1);
        chk("eret_pc", o_new_pc, 32'h80001234);
        excp_req = 0; step();
        chk("flush_cycle_stall", {26'd0, o_stall}, 32'd0);
        chk("flush_cycle_flush", {31'd0, o_flush}, 32'd0);
        step();
        chk("ex_resume", {26'd0, o_stall}, 32'h0f);
        idle(); step();

        // MEM watchdog
        fire_idx = 0; stall_run = 0;
        s_mem = 1;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (o_timeout && fire_idx == 0) begin
                fire_idx = i;
                chk("wd_pc", o_new_pc, 32'h40);
                chk("wd_flush", {31'd0, o_flush}, 32'd1);
            end
            if (fire_idx == 0 && o_stall == 6'b011111) stall_run++;
            if (i == 257) chk("wd_flush_state", {26'd0, o_stall}, 32'd0);
            if (i == 258) chk("wd_resume", {26'd0, o_stall}, 32'h1f);
        end
        chk("wd_fire_cycle", 32'(fire_idx), 32'd256);
        chk("wd_stall_run", 32'(stall_run), 32'd255);
        idle(); step();

        // exception in the watchdog-fire cycle
        s_mem = 1;
        repeat (255) step();
        excp_req = 1; excp_type = 32'h8; step();
        chk("excp_over_wd_tmo", {31'd0, o_timeout}, 32'd0);
        chk("excp_over_wd_pc", o_new_pc, 32'h20);
        excp_req = 0; step();
        step();
        chk("wd_cleared_stall", {26'd0, o_stall}, 32'h1f);

        // asynchronous reset mid-stall, checked before any clock edge
        #3;
        chk("pre_rst_stall", {26'd0, stall}, 32'h1f);
        rst = 1;
        #1;
        chk("async_rst_stall", {26'd0, stall}, 32'd0);
        chk("async_rst_flush", {31'd0, flush | timeout}, 32'd0);
        chk("async_rst_pc", new_pc, 32'd0);
        @(posedge clk);
        model_reset();
        #1;
        rst = 0;
        step();
        chk("post_rst_stall", {26'd0, o_stall}, 32'h1f);

        // performance counters: 10 stalls, 2 flushes, then clear
        idle();
        rst = 1; #1; model_reset(); @(posedge clk); #1; rst = 0;
        s_id = 1; repeat (10) step();
        s_id = 0;
        repeat (2) begin
            excp_req = 1; step();
            excp_req = 0; step();
        end
        step();
`ifdef STALL_PERF_CNT_EN
        chk("perf_stalls", stall_cycles, 32'd10);
        chk("perf_flushes", {16'd0, flush_count}, 32'd2);
`else
        chk("perf_stalls", stall_cycles, 32'd0);
        chk("perf_flushes", {16'd0, flush_count}, 32'd0);
`endif
        perf_clr = 1; step();
        perf_clr = 0; step();
        chk("perf_clr_stalls", stall_cycles, 32'd0);
        chk("perf_clr_flushes", {16'd0, flush_count}, 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            s_if = 1'($urandom_range(0, 1));
            s_id = 1'($urandom_range(0, 3) == 0);
            s_ex = 1'($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0) s_mem = ~s_mem;
            excp_req = 1'($urandom_range(0, 39) == 0);
            excp_type = ($urandom_range(0, 1) == 0) ? 32'he : $urandom;
            epc = $urandom;
            perf_clr = 1'($urandom_range(0, 99) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
